// File: rtl/vga_scanout_pkg.sv
// Shared VGA 640x480@60 timing constants, framebuffer geometry and small helpers
// used by the timing generator and the scanout datapath.
package vga_scanout_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned COLOR_W   = 10;

  // Sync/blank bundle carried down the pixel pipeline (syncs active-low).
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

  // Half-resolution framebuffer address; y*320 built from shifts (max 76799).
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] h,
                                                input logic [CNT_W-1:0] v);
    logic [ADDR_W-1:0] y;
    y = ADDR_W'(v >> 1);
    return (y << 8) + (y << 6) + ADDR_W'(h >> 1);
  endfunction

  function automatic logic [COLOR_W-1:0] expand(input logic b);
    return {COLOR_W{b}};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, h/v raster counters, frame-start pulse and raw
// sync/active decode for the VGA scanout.
module vga_timing
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             phase,
  output logic             running,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             frame_start,
  output logic             active_c,
  output logic             hs_n_c,
  output logic             vs_n_c
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  // First tick after reset re-enters (0,0) so every frame opens with frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= 1'b0;
      running     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      phase       <= ~phase;
      frame_start <= 1'b0;
      if (phase) begin
        if (!running) begin
          running     <= 1'b1;
          h_cnt       <= '0;
          v_cnt       <= '0;
          frame_start <= 1'b1;
        end else if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt       <= '0;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + CNT_W'(1);
          end
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign active_c = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign hs_n_c   = !((h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI));
  assign vs_n_c   = !((v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI));

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: framebuffer addressing, two-tick sync/blank pipeline aligned
// with the synchronous RAM read, and 1-bit to 10-bit colour expansion.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [2:0]         mem_rdata,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               VGA_CLK,
  output logic               frame_start
);

  logic             pix_tick;
  logic             running;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active_c;
  logic             hs_n_c;
  logic             vs_n_c;
  sync_t            raw_c;
  sync_t            stage1;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .phase       (pix_tick),
    .running     (running),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .frame_start (frame_start),
    .active_c    (active_c),
    .hs_n_c      (hs_n_c),
    .vs_n_c      (vs_n_c)
  );

  assign raw_c      = '{hs_n: hs_n_c, vs_n: vs_n_c, active: active_c};
  assign VGA_CLK    = pix_tick;
  assign VGA_SYNC_N = 1'b0;

  // Address follows the counters one clk later; the RAM answers one clk after
  // that, so RAM data for a pixel is ready by the second tick after it enters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      stage1      <= SYNC_IDLE;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      mem_addr <= active_c ? fb_addr(h_cnt, v_cnt) : '0;
      if (pix_tick) begin
        stage1      <= running ? raw_c : SYNC_IDLE;
        VGA_HS      <= stage1.hs_n;
        VGA_VS      <= stage1.vs_n;
        VGA_BLANK_N <= stage1.active;
        VGA_R       <= expand(stage1.active & mem_rdata[2]);
        VGA_G       <= expand(stage1.active & mem_rdata[1]);
        VGA_B       <= expand(stage1.active & mem_rdata[0]);
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster: an arithmetic raster model is
// compared every clk, plus hand-computed literal expectations.
module tb_vga_scanout;

  localparam int HV = 16, HF = 4, HSW = 6, HB = 4;
  localparam int VV = 12, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB;   // 30
  localparam int VT = VV + VF + VSW + VB;   // 19
  localparam int FT = HT * VT;              // 570 ticks per frame

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] mem_addr;
  logic [2:0]  mem_rdata = 3'b000;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;

  int checks = 0;
  int failures = 0;
  int n = 0;            // clk edges since reset release
  bit const_mode = 1'b0;

  vga_scanout #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_CLK     (VGA_CLK),
    .frame_start (frame_start)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Synchronous RAM: data = addr[2:0], or all-ones in constant mode.
  always @(posedge clk) mem_rdata <= const_mode ? 3'b111 : mem_addr[2:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", nm, act, exp, n, $time);
    end
  endtask

  function automatic int addr_of(input int h, input int v);
    if (h < HV && v < VV) return (v / 2) * 320 + h / 2;
    return 0;
  endfunction

  // Raster model: pixel k enters the counters at edge 2+2k, its address shows
  // one clk later and its sync/colour four clks later.
  always @(negedge clk) begin : model_cmp
    int k, h, v, a;
    bit act;
    logic [2:0] c;
    logic [31:0] e_clk, e_fs, e_addr, e_hs, e_vs, e_bn, e_r, e_g, e_b;
    e_clk = 0; e_fs = 0; e_addr = 0; e_hs = 1; e_vs = 1;
    e_bn = 0; e_r = 0; e_g = 0; e_b = 0;
    if (!reset) begin
      e_clk = 32'(n % 2);
      e_fs  = 32'(n >= 2 && n % 2 == 0 && ((n - 2) / 2) % FT == 0);
      if (n >= 3) begin
        k = (n - 3) / 2;
        e_addr = 32'(addr_of(k % HT, (k / HT) % VT));
      end
      if (n >= 6) begin
        k = (n - 6) / 2;
        h = k % HT;
        v = (k / HT) % VT;
        act = (h < HV) && (v < VV);
        a = addr_of(h, v);
        c = const_mode ? 3'b111 : 3'(a);
        e_bn = 32'(act);
        e_hs = 32'(!(h >= HV + HF && h < HV + HF + HSW));
        e_vs = 32'(!(v >= VV + VF && v < VV + VF + VSW));
        e_r = (act && c[2]) ? 32'h3FF : 32'h0;
        e_g = (act && c[1]) ? 32'h3FF : 32'h0;
        e_b = (act && c[0]) ? 32'h3FF : 32'h0;
      end
    end
    chk("m_vga_clk",  32'(VGA_CLK),     e_clk);
    chk("m_frame_st", 32'(frame_start), e_fs);
    chk("m_mem_addr", 32'(mem_addr),    e_addr);
    chk("m_hs",       32'(VGA_HS),      e_hs);
    chk("m_vs",       32'(VGA_VS),      e_vs);
    chk("m_blank_n",  32'(VGA_BLANK_N), e_bn);
    chk("m_r",        32'(VGA_R),       e_r);
    chk("m_g",        32'(VGA_G),       e_g);
    chk("m_b",        32'(VGA_B),       e_b);
    chk("m_sync_n",   32'(VGA_SYNC_N),  32'h0);
  end

  // Returns on the negedge where n equals target; a missed target is a failure.
  task automatic wait_n(input int target);
    int i;
    i = 0;
    @(negedge clk);
    while (n != target && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (n != target) begin
      checks++;
      failures++;
      $display("FAIL wait_n: got n=%0d expected n=%0d", n, target);
    end
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_blank_n", 32'(VGA_BLANK_N), 32'h0);
    chk("rst_hs", 32'(VGA_HS), 32'h1);
    reset = 1'b0;

    wait_n(1);    chk("lit_clk_n1", 32'(VGA_CLK), 32'h1);
                  chk("lit_fs_n1", 32'(frame_start), 32'h0);
    wait_n(2);    chk("lit_fs_n2", 32'(frame_start), 32'h1);
    wait_n(3);    chk("lit_fs_n3", 32'(frame_start), 32'h0);
    wait_n(44);   chk("lit_hs_h19", 32'(VGA_HS), 32'h1);
    wait_n(46);   chk("lit_hs_h20", 32'(VGA_HS), 32'h0);
    wait_n(57);   chk("lit_hs_h25", 32'(VGA_HS), 32'h0);
    wait_n(58);   chk("lit_hs_h26", 32'(VGA_HS), 32'h1);
    wait_n(187);  chk("lit_addr_h2v3", 32'(mem_addr), 32'd321);
    wait_n(190);  chk("lit_b_h2v3", 32'(VGA_B), 32'h3FF);
                  chk("lit_r_h2v3", 32'(VGA_R), 32'h0);
                  chk("lit_bn_h2v3", 32'(VGA_BLANK_N), 32'h1);
    wait_n(693);  chk("lit_addr_last", 32'(mem_addr), 32'd1607);
    wait_n(845);  chk("lit_vs_v13", 32'(VGA_VS), 32'h1);
    wait_n(846);  chk("lit_vs_v14", 32'(VGA_VS), 32'h0);
    wait_n(965);  chk("lit_vs_v15", 32'(VGA_VS), 32'h0);
    wait_n(966);  chk("lit_vs_v16", 32'(VGA_VS), 32'h1);
    wait_n(1140); chk("lit_fs_lastpix", 32'(frame_start), 32'h0);
    wait_n(1142); chk("lit_fs_frame2", 32'(frame_start), 32'h1);
    wait_n(1147); chk("lit_addr_wrap", 32'(mem_addr), 32'd1);

    // Mid-line asynchronous reset at h=10, v=5 of the second frame.
    wait_n(1463);
    chk("lit_addr_pre_rst", 32'(mem_addr), 32'd645);
    chk("lit_r_pre_rst", 32'(VGA_R), 32'h3FF);
    #3 reset = 1'b1;
    #1;
    chk("async_clk", 32'(VGA_CLK), 32'h0);
    chk("async_addr", 32'(mem_addr), 32'h0);
    chk("async_r", 32'(VGA_R), 32'h0);
    chk("async_bn", 32'(VGA_BLANK_N), 32'h0);
    chk("async_hs", 32'(VGA_HS), 32'h1);
    chk("async_vs", 32'(VGA_VS), 32'h1);
    chk("async_fs", 32'(frame_start), 32'h0);
    const_mode = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    wait_n(2);    chk("lit_fs_restart", 32'(frame_start), 32'h1);
    wait_n(6);    chk("lit_r_const", 32'(VGA_R), 32'h3FF);
                  chk("lit_bn_const", 32'(VGA_BLANK_N), 32'h1);
    wait_n(46);   chk("lit_g_const_sync", 32'(VGA_G), 32'h0);
    wait_n(1142); chk("lit_fs_frame2b", 32'(frame_start), 32'h1);
    wait_n(1150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameters V_VISIBLE, V_FRONT, V_SYNC and V_BACK, defaults 480, 10, 2 and 33, meaning the vertical equivalents in lines.
REQ-006 The block SHALL have port clk, input, 1 bit: the 50 MHz system clock and the only clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port mem_addr, output, 17 bits: framebuffer read address for the 320x240 buffer.
REQ-009 The block SHALL have port mem_rdata, input, 3 bits: pixel colour {R,G,B}, valid one clk after mem_addr.
REQ-010 The block SHALL have ports VGA_R, VGA_G and VGA_B, output, 10 bits each: colour channels.
REQ-011 The block SHALL have ports VGA_HS and VGA_VS, output, 1 bit each: syncs, active-low.
REQ-012 The block SHALL have ports VGA_BLANK_N and VGA_SYNC_N, output, 1 bit each: DAC blank (low = blank) and composite sync (held 0).
REQ-013 The block SHALL have port VGA_CLK, output, 1 bit: 25 MHz pixel clock.
REQ-014 The block SHALL have port frame_start, output, 1 bit: one-clk pulse at the start of each frame.

Function
REQ-015 The block SHALL toggle a phase bit every clk; a pixel tick SHALL occur on clk edges where phase==1, and VGA_CLK SHALL equal the registered phase.
REQ-016 On each pixel tick, h_cnt SHALL increment 0..799 and wrap to 0.
REQ-017 On the tick where h_cnt wraps, v_cnt SHALL increment 0..524 and wrap to 0.
REQ-018 When both counters wrap on the same tick, both SHALL reach 0 on that tick.
REQ-019 Active region: h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
REQ-020 Raw hsync SHALL be low for h_cnt in 656..751 inclusive.
REQ-021 Raw vsync SHALL be low for v_cnt in 490..491 inclusive.
REQ-022 mem_addr SHALL equal (v_cnt>>1)*320 + (h_cnt>>1) in the active region and 0 otherwise.
REQ-023 The multiply in REQ-022 SHALL be formed as (y<<8)+(y<<6) without a multiplier, giving a maximum of 76799.
REQ-024 mem_addr SHALL be registered and update on the clk following the pixel tick.
REQ-025 HS, VS and blank SHALL be delayed through a 2-tick pipeline so that they align with returned mem_rdata.
REQ-026 The colour register SHALL capture mem_rdata on the next pixel tick.
REQ-027 Each colour output channel SHALL be its 1-bit input replicated to 10 bits (1 -> 10'h3FF, 0 -> 0).
REQ-028 When the delayed blank is asserted, the colour outputs SHALL be forced to 0 and VGA_BLANK_N driven 0.
REQ-029 frame_start SHALL pulse for exactly one clk on the tick where h_cnt=0 and v_cnt=0 enter the counters, once per frame.
REQ-030 Frame period SHALL be 800*525 pixel ticks = 840000 clk.

Reset
REQ-031 While reset=1, regardless of clk: phase=0, VGA_CLK=0, h_cnt=0, v_cnt=0, mem_addr=0, colour outputs=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_SYNC_N=0, frame_start=0, pipeline stages cleared to blank/no-sync.
REQ-032 Reset asserted mid-line SHALL abort the frame immediately.
REQ-033 After reset release, the first pixel tick SHALL be on the second clk edge, starting a fresh frame with frame_start pulsed.

Structure
REQ-034 A shared package SHALL hold the timing constants (640/16/96/48, 480/10/2/33), totals 800/525, FB_WIDTH=320, FB_HEIGHT=240 and ADDR_W=17.
REQ-035 One sub-module, vga_timing, SHALL contain the counters, sync and active generation.
REQ-036 vga_scanout SHALL hold the addressing, the pipeline and the colour expansion.

Verification
REQ-037 Reset hold then release -> VGA_CLK toggles at 25 MHz; first frame_start at the 2nd clk; next frame_start exactly 840000 clk later.
REQ-038 Count HS pulses -> low width 192 clk, period 1600 clk; VS low for 2 lines (3200 clk), starting at line 490.
REQ-039 Model a sync RAM with data = addr[2:0] -> pixel (h=2,v=3) reads addr 321; colour appears 2 ticks later aligned with active BLANK_N; last active pixel reads addr 76799.
REQ-040 mem_rdata=3'b111 constant -> VGA_R/G/B=10'h3FF only in the active window, 0 and BLANK_N=0 in the porches and sync.
REQ-041 Assert reset at h_cnt=400, v_cnt=200 for 3 clk -> all outputs at their reset values immediately (asynchronously); restart from h=v=0.
REQ-042 Run to h=799, v=524 -> next tick gives h=0, v=0 with frame_start, no extra line.
